// File: rtl/sc_life_ctrl_pkg.sv
// Shared state codes and default timing for the life-loss controller.
package sc_life_ctrl_pkg;

  localparam int unsigned STATE_W = 3;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_INIT  = 3'd1;
  localparam state_t ST_PLAY  = 3'd2;
  localparam state_t ST_HIT   = 3'd3;
  localparam state_t ST_CHECK = 3'd4;
  localparam state_t ST_GRACE = 3'd5;
  localparam state_t ST_OVER  = 3'd6;

  // One second of invulnerability at 50 MHz
  localparam int unsigned DEF_GRACE_CYCLES = 50_000_000;
  localparam int unsigned DEF_GRACE_W      = 26;

endpackage

// File: rtl/sc_life_loss_controller_if.sv
// Command/status bundle between the controller, collision detector and lives register.
interface sc_life_loss_controller_if #(
  parameter int unsigned LIVES_W = 2
);
  logic               LifeCtrl_start_InLow;
  logic               LifeCtrl_collision_InLow;
  logic [LIVES_W-1:0] LifeCtrl_lives_InBUS;
  logic               LifeCtrl_noLives_InLow;
  logic               LifeCtrl_clear_OutLow;
  logic               LifeCtrl_substract_life_OutLow;
  logic               LifeCtrl_invulnerable_OutHigh;
  logic               LifeCtrl_gameOver_OutHigh;
  logic [2:0]         LifeCtrl_state_OutBUS;

  modport master (
    input  LifeCtrl_start_InLow, LifeCtrl_collision_InLow,
           LifeCtrl_lives_InBUS, LifeCtrl_noLives_InLow,
    output LifeCtrl_clear_OutLow, LifeCtrl_substract_life_OutLow,
           LifeCtrl_invulnerable_OutHigh, LifeCtrl_gameOver_OutHigh,
           LifeCtrl_state_OutBUS
  );

  modport slave (
    output LifeCtrl_start_InLow, LifeCtrl_collision_InLow,
           LifeCtrl_lives_InBUS, LifeCtrl_noLives_InLow,
    input  LifeCtrl_clear_OutLow, LifeCtrl_substract_life_OutLow,
           LifeCtrl_invulnerable_OutHigh, LifeCtrl_gameOver_OutHigh,
           LifeCtrl_state_OutBUS
  );
endinterface

// File: rtl/sc_grace_timer.sv
// Invulnerability down-counter: loads GRACE_CYCLES-1, counts to zero while enabled.
module sc_grace_timer
  import sc_life_ctrl_pkg::*;
#(
  parameter int unsigned GRACE_CYCLES = DEF_GRACE_CYCLES,
  parameter int unsigned GRACE_W      = DEF_GRACE_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic enable,
  output logic done_c
);

  logic [GRACE_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= GRACE_W'(GRACE_CYCLES - 1);
    end else if (enable && (count != '0)) begin
      count <= count - GRACE_W'(1);
    end
  end

  assign done_c = (count == '0);

endmodule

// File: rtl/sc_life_loss_controller.sv
// Life-loss game-flow controller driving the lives register clear/subtract strobes.
// Timed post-hit invulnerability is built only when LIFECTRL_GRACE_EN is defined.
module sc_life_loss_controller
  import sc_life_ctrl_pkg::*;
#(
  parameter int unsigned LIVES_W      = 2,
  parameter int unsigned GRACE_CYCLES = DEF_GRACE_CYCLES,
  parameter int unsigned GRACE_W      = DEF_GRACE_W
) (
  input  logic                      LifeCtrl_CLOCK_50,
  input  logic                      LifeCtrl_RESET_InLow,
  sc_life_loss_controller_if.master bus
);

  if ((GRACE_CYCLES < 1) || ((GRACE_W < 32) && (GRACE_CYCLES >= (32'd1 << GRACE_W))))
  begin : g_bad_cfg
    $error("sc_life_loss_controller: GRACE_CYCLES must be >=1 and fit in GRACE_W bits");
  end

  state_t state, state_next;
  logic   clear_q, sub_q, inv_q, over_q;
  logic   clear_d, sub_d, inv_d, over_d;
  logic   lives_zero;

  assign lives_zero = !bus.LifeCtrl_noLives_InLow || (bus.LifeCtrl_lives_InBUS == LIVES_W'(0));

`ifdef LIFECTRL_GRACE_EN
  logic grace_load, grace_done;

  sc_grace_timer #(
    .GRACE_CYCLES (GRACE_CYCLES),
    .GRACE_W      (GRACE_W)
  ) u_grace_timer (
    .clk    (LifeCtrl_CLOCK_50),
    .rst_n  (LifeCtrl_RESET_InLow),
    .load   (grace_load),
    .enable (state == ST_GRACE),
    .done_c (grace_done)
  );
`endif

  // State and registered Moore outputs
  always_ff @(posedge LifeCtrl_CLOCK_50 or negedge LifeCtrl_RESET_InLow) begin
    if (!LifeCtrl_RESET_InLow) begin
      state   <= ST_IDLE;
      clear_q <= 1'b1;
      sub_q   <= 1'b1;
      inv_q   <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state   <= state_next;
      clear_q <= clear_d;
      sub_q   <= sub_d;
      inv_q   <= inv_d;
      over_q  <= over_d;
    end
  end

  // Next-state logic; collision has priority over the zero guard in PLAY
  always_comb begin
    state_next = state;
`ifdef LIFECTRL_GRACE_EN
    grace_load = 1'b0;
`endif
    case (state)
      ST_IDLE:  if (!bus.LifeCtrl_start_InLow) state_next = ST_INIT;
      ST_INIT:  state_next = ST_PLAY;
      ST_PLAY: begin
        if (!bus.LifeCtrl_collision_InLow) state_next = ST_HIT;
        else if (lives_zero)               state_next = ST_OVER;
      end
      ST_HIT:   state_next = ST_CHECK;
      ST_CHECK: begin
        if (!bus.LifeCtrl_noLives_InLow) begin
          state_next = ST_OVER;
        end else begin
`ifdef LIFECTRL_GRACE_EN
          state_next = ST_GRACE;
          grace_load = 1'b1;
`else
          if (bus.LifeCtrl_collision_InLow) state_next = ST_PLAY;
`endif
        end
      end
`ifdef LIFECTRL_GRACE_EN
      ST_GRACE: if (grace_done) state_next = ST_PLAY;
`endif
      ST_OVER:  if (!bus.LifeCtrl_start_InLow) state_next = ST_INIT;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from the upcoming state so they register in step with it
  always_comb begin
    clear_d = (state_next != ST_INIT);
    sub_d   = (state_next != ST_HIT);
`ifdef LIFECTRL_GRACE_EN
    inv_d   = (state_next == ST_GRACE);
`else
    inv_d   = 1'b0;
`endif
    over_d  = (state_next == ST_OVER);
  end

  assign bus.LifeCtrl_clear_OutLow          = clear_q;
  assign bus.LifeCtrl_substract_life_OutLow = sub_q;
  assign bus.LifeCtrl_invulnerable_OutHigh  = inv_q;
  assign bus.LifeCtrl_gameOver_OutHigh      = over_q;
  assign bus.LifeCtrl_state_OutBUS          = state;

endmodule
